clock_time_counter: RTL and testbench

- Parametrised successor to the per-digit clock counters: one block holding all six BCD time digits (h10 h1 m10 m1 s10 s1) with an internal carry chain.
- Selectable 24 h or 12 h (AM/PM) format.
- Keypad-style direct digit load plus up/down digit adjust, with range validation.
- Fully synchronous to CLKk: counts on a 1 Hz tick strobe and emits a one-cycle day_pulse at midnight for downstream date logic.

---
 rtl/clock_time_counter.sv | 216 +++++++++++++++++++++
 tb/tb_clock_time_counter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// clock_time_counter: six BCD time-of-day digits (h10 h1 m10 m1 s10 s1) with
// an internal carry chain, 24 h or 12 h (AM/PM) format, keypad-style digit
// load and up/down adjust with range checking, and a midnight day_pulse.
// Optional feature: define CLOCK_DAY_OF_WEEK_EN to add a day-of-week output
// (dow) that advances on every day_pulse and is selectable as set_digit 7.
module clock_time_counter #(
    parameter int HOUR_MODE = 24,
    parameter int RESET_PM  = 0
) (
    input  logic       CLKk,
    input  logic       RST,
    input  logic       tick,
    input  logic       set_en,
    input  logic [2:0] set_digit,
    input  logic [3:0] set_value,
    input  logic       set_load,
    input  logic       up,
    input  logic       down,
    output logic [3:0] h10,
    output logic [3:0] h1,
    output logic [3:0] m10,
    output logic [3:0] m1,
    output logic [3:0] s10,
    output logic [3:0] s1,
    output logic       pm,
    output logic       day_pulse,
    output logic       set_err
`ifdef CLOCK_DAY_OF_WEEK_EN
    ,
    output logic [2:0] dow
`endif
);

    // HOUR_MODE is expected to be 12 or 24; anything other than 12 builds a 24 h clock.
    localparam bit         IS12    = (HOUR_MODE == 12);
    localparam logic [3:0] H10_MAX = IS12 ? 4'd1 : 4'd2;
    localparam logic [3:0] RST_H10 = IS12 ? 4'd1 : 4'd0;
    localparam logic [3:0] RST_H1  = IS12 ? 4'd2 : 4'd0;
    localparam logic       RST_PM  = IS12 && (RESET_PM != 0);

    // Smallest legal hour-units digit for a given hour-tens digit.
    function automatic logic [3:0] h1_min(input logic [3:0] tens);
        return (IS12 && tens == 4'd0) ? 4'd1 : 4'd0;
    endfunction

    // Largest legal hour-units digit for a given hour-tens digit.
    function automatic logic [3:0] h1_max(input logic [3:0] tens);
        if (IS12) return (tens == 4'd0) ? 4'd9 : 4'd2;
        else      return (tens == 4'd2) ? 4'd3 : 4'd9;
    endfunction

    logic [3:0] n_h10, n_h1, n_m10, n_m1, n_s10, n_s1;
    logic       n_pm, n_day, n_err;
    logic [3:0] sel_cur, sel_min, sel_max, new_val;
    logic       sel_num, wr;
`ifdef CLOCK_DAY_OF_WEEK_EN
    logic [2:0] n_dow;
`endif

    // Current value and legal range of the digit picked by set_digit.
    always_comb begin
        sel_cur = 4'd0;
        sel_min = 4'd0;
        sel_max = 4'd0;
        sel_num = 1'b1;
        case (set_digit)
            3'd0: begin sel_cur = h10; sel_max = H10_MAX; end
            3'd1: begin sel_cur = h1; sel_min = h1_min(h10); sel_max = h1_max(h10); end
            3'd2: begin sel_cur = m10; sel_max = 4'd5; end
            3'd3: begin sel_cur = m1; sel_max = 4'd9; end
            3'd4: begin sel_cur = s10; sel_max = 4'd5; end
            3'd5: begin sel_cur = s1; sel_max = 4'd9; end
`ifdef CLOCK_DAY_OF_WEEK_EN
            3'd7: begin sel_cur = {1'b0, dow}; sel_max = 4'd6; end
`endif
            default: sel_num = 1'b0;
        endcase
    end

    // Next time value: set-mode edits take precedence, otherwise a tick runs the full carry chain.
    always_comb begin
        n_h10   = h10;
        n_h1    = h1;
        n_m10   = m10;
        n_m1    = m1;
        n_s10   = s10;
        n_s1    = s1;
        n_pm    = pm;
        n_day   = 1'b0;
        n_err   = 1'b0;
        new_val = sel_cur;
        wr      = 1'b0;
`ifdef CLOCK_DAY_OF_WEEK_EN
        n_dow   = dow;
`endif
        if (set_en) begin
            if (set_load) begin
                if (set_digit == 3'd6) begin
                    if (IS12) n_pm = set_value[0];
                    else      n_err = 1'b1;
                end else if (sel_num && set_value >= sel_min && set_value <= sel_max) begin
                    new_val = set_value;
                    wr      = 1'b1;
                end else begin
                    n_err = 1'b1;
                end
            end else if (up != down) begin
                if (set_digit == 3'd6) begin
                    if (IS12) n_pm = ~pm;
                    else      n_err = 1'b1;
                end else if (sel_num) begin
                    wr = 1'b1;
                    if (up) new_val = (sel_cur >= sel_max) ? sel_min : sel_cur + 4'd1;
                    else    new_val = (sel_cur <= sel_min) ? sel_max : sel_cur - 4'd1;
                end else begin
                    n_err = 1'b1;
                end
            end
            if (wr) begin
                case (set_digit)
                    3'd0: begin
                        n_h10 = new_val;
                        if (h1 < h1_min(new_val) || h1 > h1_max(new_val)) n_h1 = h1_min(new_val);
                    end
                    3'd1: n_h1  = new_val;
                    3'd2: n_m10 = new_val;
                    3'd3: n_m1  = new_val;
                    3'd4: n_s10 = new_val;
                    3'd5: n_s1  = new_val;
`ifdef CLOCK_DAY_OF_WEEK_EN
                    3'd7: n_dow = new_val[2:0];
`endif
                    default: ;
                endcase
            end
        end else if (tick) begin
            if (s1 != 4'd9) n_s1 = s1 + 4'd1;
            else begin
                n_s1 = 4'd0;
                if (s10 != 4'd5) n_s10 = s10 + 4'd1;
                else begin
                    n_s10 = 4'd0;
                    if (m1 != 4'd9) n_m1 = m1 + 4'd1;
                    else begin
                        n_m1 = 4'd0;
                        if (m10 != 4'd5) n_m10 = m10 + 4'd1;
                        else begin
                            n_m10 = 4'd0;
                            if (IS12) begin
                                if (h10 == 4'd1 && h1 == 4'd2) begin
                                    n_h10 = 4'd0;
                                    n_h1  = 4'd1;
                                end else if (h10 == 4'd1 && h1 == 4'd1) begin
                                    n_h1  = 4'd2;
                                    n_pm  = ~pm;
                                    n_day = pm;
                                end else if (h1 == 4'd9) begin
                                    n_h10 = 4'd1;
                                    n_h1  = 4'd0;
                                end else begin
                                    n_h1 = h1 + 4'd1;
                                end
                            end else begin
                                if (h10 == 4'd2 && h1 == 4'd3) begin
                                    n_h10 = 4'd0;
                                    n_h1  = 4'd0;
                                    n_day = 1'b1;
                                end else if (h1 == 4'd9) begin
                                    n_h10 = h10 + 4'd1;
                                    n_h1  = 4'd0;
                                end else begin
                                    n_h1 = h1 + 4'd1;
                                end
                            end
                        end
                    end
                end
            end
`ifdef CLOCK_DAY_OF_WEEK_EN
            if (n_day) n_dow = (dow == 3'd6) ? 3'd0 : dow + 3'd1;
`endif
        end
    end

    // Time, flag and pulse registers with asynchronous return to the power-on time.
    always_ff @(posedge CLKk or posedge RST) begin
        if (RST) begin
            h10       <= RST_H10;
            h1        <= RST_H1;
            m10       <= 4'd0;
            m1        <= 4'd0;
            s10       <= 4'd0;
            s1        <= 4'd0;
            pm        <= RST_PM;
            day_pulse <= 1'b0;
            set_err   <= 1'b0;
`ifdef CLOCK_DAY_OF_WEEK_EN
            dow       <= 3'd0;
`endif
        end else begin
            h10       <= n_h10;
            h1        <= n_h1;
            m10       <= n_m10;
            m1        <= n_m1;
            s10       <= n_s10;
            s1        <= n_s1;
            pm        <= n_pm;
            day_pulse <= n_day;
            set_err   <= n_err;
`ifdef CLOCK_DAY_OF_WEEK_EN
            dow       <= n_dow;
`endif
        end
    end

endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: drives a 24 h and a 12 h instance (RESET_PM=1) with
// shared stimulus; checks against a time-of-day reference model plus constant
// vectors and hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_clock_time_counter;

`ifdef CLOCK_DAY_OF_WEEK_EN
    localparam bit HAS_DOW = 1'b1;
`else
    localparam bit HAS_DOW = 1'b0;
`endif

    logic       CLKk = 1'b0;
    logic       RST;
    logic       tick, set_en, set_load, up, down;
    logic [2:0] set_digit;
    logic [3:0] set_value;

    logic [3:0] h10_24, h1_24, m10_24, m1_24, s10_24, s1_24;
    logic       pm_24, day_24, err_24;
    logic [3:0] h10_12, h1_12, m10_12, m1_12, s10_12, s1_12;
    logic       pm_12, day_12, err_12;
    logic [2:0] dow_24, dow_12;
    logic [26:0] out24, out12;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        int hh;
        int mm;
        int ss;
        int dow;
        bit pm;
        bit day;
        bit err;
    } model_t;

    typedef struct {
        bit          tk;
        bit          se;
        int          sd;
        int          sv;
        bit          ld;
        bit          u;
        bit          dn;
        logic [23:0] t;
        logic        day;
        logic        err;
    } vec_t;

    model_t m24, m12;
    vec_t   vecs[$];

    clock_time_counter #(.HOUR_MODE(24), .RESET_PM(0)) dut24 (
        .CLKk(CLKk), .RST(RST), .tick(tick), .set_en(set_en),
        .set_digit(set_digit), .set_value(set_value), .set_load(set_load),
        .up(up), .down(down),
        .h10(h10_24), .h1(h1_24), .m10(m10_24), .m1(m1_24), .s10(s10_24), .s1(s1_24),
        .pm(pm_24), .day_pulse(day_24), .set_err(err_24)
`ifdef CLOCK_DAY_OF_WEEK_EN
        , .dow(dow_24)
`endif
    );

    clock_time_counter #(.HOUR_MODE(12), .RESET_PM(1)) dut12 (
        .CLKk(CLKk), .RST(RST), .tick(tick), .set_en(set_en),
        .set_digit(set_digit), .set_value(set_value), .set_load(set_load),
        .up(up), .down(down),
        .h10(h10_12), .h1(h1_12), .m10(m10_12), .m1(m1_12), .s10(s10_12), .s1(s1_12),
        .pm(pm_12), .day_pulse(day_12), .set_err(err_12)
`ifdef CLOCK_DAY_OF_WEEK_EN
        , .dow(dow_12)
`endif
    );

`ifndef CLOCK_DAY_OF_WEEK_EN
    assign dow_24 = 3'd0;
    assign dow_12 = 3'd0;
`endif

    assign out24 = {h10_24, h1_24, m10_24, m1_24, s10_24, s1_24, pm_24, day_24, err_24};
    assign out12 = {h10_12, h1_12, m10_12, m1_12, s10_12, s1_12, pm_12, day_12, err_12};

    always #5 CLKk = ~CLKk;

    function automatic bit hour_ok(bit is12, int h);
        return is12 ? (h >= 1 && h <= 12) : (h >= 0 && h <= 23);
    endfunction

    // Keep the hour if legal, else the smallest legal hour with these tens.
    function automatic int fix_hour(bit is12, int tens, int ones);
        int r;
        bit found;
        r = 0;
        found = 1'b0;
        if (hour_ok(is12, tens * 10 + ones)) return tens * 10 + ones;
        for (int k = 0; k < 10; k++) begin
            if (!found && hour_ok(is12, tens * 10 + k)) begin
                r = tens * 10 + k;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic model_t model_reset(bit is12, bit rpm);
        model_t s;
        s.hh = is12 ? 12 : 0;
        s.mm = 0;
        s.ss = 0;
        s.dow = 0;
        s.pm = is12 ? rpm : 1'b0;
        s.day = 1'b0;
        s.err = 1'b0;
        return s;
    endfunction

    function automatic model_t model_step(model_t s, bit is12, bit tk, bit se,
                                          int sd, int sv, bit ld, bit u, bit dn);
        model_t n;
        int t, h24, tens, dir, top, cand;
        bit found;
        n = s;
        n.day = 1'b0;
        n.err = 1'b0;
        tens = s.hh / 10;
        if (!se) begin
            if (tk) begin
                h24 = is12 ? (s.hh % 12 + (s.pm ? 12 : 0)) : s.hh;
                t = (h24 * 3600 + s.mm * 60 + s.ss + 1) % 86400;
                h24 = t / 3600;
                n.mm = (t / 60) % 60;
                n.ss = t % 60;
                if (is12) begin
                    n.pm = (h24 >= 12);
                    n.hh = (h24 % 12 == 0) ? 12 : h24 % 12;
                end else begin
                    n.hh = h24;
                end
                if (t == 0) begin
                    n.day = 1'b1;
                    n.dow = (s.dow + 1) % 7;
                end
            end
        end else if (ld) begin
            case (sd)
                0: if (sv <= (is12 ? 1 : 2)) n.hh = fix_hour(is12, sv, s.hh % 10); else n.err = 1'b1;
                1: if (sv <= 9 && hour_ok(is12, tens * 10 + sv)) n.hh = tens * 10 + sv; else n.err = 1'b1;
                2: if (sv <= 5) n.mm = sv * 10 + s.mm % 10; else n.err = 1'b1;
                3: if (sv <= 9) n.mm = (s.mm / 10) * 10 + sv; else n.err = 1'b1;
                4: if (sv <= 5) n.ss = sv * 10 + s.ss % 10; else n.err = 1'b1;
                5: if (sv <= 9) n.ss = (s.ss / 10) * 10 + sv; else n.err = 1'b1;
                6: if (is12) n.pm = ((sv % 2) == 1); else n.err = 1'b1;
                default: if (HAS_DOW && sv <= 6) n.dow = sv; else n.err = 1'b1;
            endcase
        end else if (u != dn) begin
            dir = u ? 1 : -1;
            case (sd)
                0: begin
                    top = is12 ? 2 : 3;
                    n.hh = fix_hour(is12, (tens + dir + top) % top, s.hh % 10);
                end
                1: begin
                    found = 1'b0;
                    for (int k = 1; k <= 10; k++) begin
                        cand = tens * 10 + (s.hh % 10 + dir * k + 20) % 10;
                        if (!found && hour_ok(is12, cand)) begin
                            n.hh = cand;
                            found = 1'b1;
                        end
                    end
                end
                2: n.mm = ((s.mm / 10 + dir + 6) % 6) * 10 + s.mm % 10;
                3: n.mm = (s.mm / 10) * 10 + (s.mm % 10 + dir + 10) % 10;
                4: n.ss = ((s.ss / 10 + dir + 6) % 6) * 10 + s.ss % 10;
                5: n.ss = (s.ss / 10) * 10 + (s.ss % 10 + dir + 10) % 10;
                6: if (is12) n.pm = !s.pm; else n.err = 1'b1;
                default: if (HAS_DOW) n.dow = (s.dow + dir + 7) % 7; else n.err = 1'b1;
            endcase
        end
        return n;
    endfunction

    function automatic logic [26:0] model_pack(model_t s);
        return {4'(s.hh / 10), 4'(s.hh % 10), 4'(s.mm / 10), 4'(s.mm % 10),
                4'(s.ss / 10), 4'(s.ss % 10), s.pm, s.day, s.err};
    endfunction

    function automatic string fmt(logic [26:0] v);
        return $sformatf("%h%h:%h%h:%h%h pm=%b day=%b err=%b", v[26:23], v[22:19],
                         v[18:15], v[14:11], v[10:7], v[6:3], v[2], v[1], v[0]);
    endfunction

    function automatic vec_t mk(bit tk, bit se, int sd, int sv, bit ld, bit u, bit dn,
                                logic [23:0] t, logic day, logic err);
        vec_t v;
        v.tk = tk; v.se = se; v.sd = sd; v.sv = sv; v.ld = ld; v.u = u; v.dn = dn;
        v.t = t; v.day = day; v.err = err;
        return v;
    endfunction

    task automatic applyStimulus(input bit tk, input bit se, input int sd, input int sv,
                                 input bit ld, input bit u, input bit dn);
        tick      = tk;
        set_en    = se;
        set_digit = 3'(sd);
        set_value = 4'(sv);
        set_load  = ld;
        up        = u;
        down      = dn;
        @(posedge CLKk);
        #1;
        m24 = model_step(m24, 1'b0, tk, se, sd, sv, ld, u, dn);
        m12 = model_step(m12, 1'b1, tk, se, sd, sv, ld, u, dn);
    endtask

    task automatic checkOutput(input string name, input logic [26:0] act, input logic [26:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %s expected %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic checkDow(input string name, input logic [2:0] act, input int exp);
        assertions++;
        if (act !== 3'(exp)) begin
            failures++;
            $display("[TB] FAIL %s: got dow=%0d expected dow=%0d", name, act, exp);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput({name, "/24h"}, out24, model_pack(m24));
        checkOutput({name, "/12h"}, out12, model_pack(m12));
        if (HAS_DOW) begin
            checkDow({name, "/dow24"}, dow_24, m24.dow);
            checkDow({name, "/dow12"}, dow_12, m12.dow);
        end
    endtask

    initial begin
        RST = 1'b1;
        tick = 1'b0; set_en = 1'b0; set_digit = 3'd0; set_value = 4'd0;
        set_load = 1'b0; up = 1'b0; down = 1'b0;
        m24 = model_reset(1'b0, 1'b0);
        m12 = model_reset(1'b1, 1'b1);

        // Constant vectors for the 24 h instance; the 12 h instance follows the model.
        vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0, 24'h200000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 3, 1, 0, 0, 24'h230000, 0, 0));
        vecs.push_back(mk(0, 1, 2, 5, 1, 0, 0, 24'h235000, 0, 0));
        vecs.push_back(mk(0, 1, 3, 9, 1, 0, 0, 24'h235900, 0, 0));
        vecs.push_back(mk(0, 1, 4, 5, 1, 0, 0, 24'h235950, 0, 0));
        vecs.push_back(mk(0, 1, 5, 8, 1, 0, 0, 24'h235958, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 24'h235958, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 24'h235959, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 24'h000000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 24'h000000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 24'h100000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 5, 1, 0, 0, 24'h150000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0, 24'h200000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7, 1, 0, 0, 24'h200000, 0, 1));
        vecs.push_back(mk(0, 1, 2, 6, 1, 0, 0, 24'h200000, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 24'h200000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 24'h210000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 24'h200000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 24'h230000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 24'h200000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 24'h200000, 0, 0));
        vecs.push_back(mk(0, 1, 6, 1, 1, 0, 0, 24'h200000, 0, 1));
        vecs.push_back(mk(0, 1, 7, 9, 1, 0, 0, 24'h200000, 0, 1));
        vecs.push_back(mk(0, 1, 5, 7, 1, 1, 0, 24'h200007, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 24'h200008, 0, 0));

        repeat (2) @(posedge CLKk);
        #1;
        checkOutput("reset/24h", out24, {24'h000000, 3'b000});
        checkOutput("reset/12h", out12, {24'h120000, 3'b100});
        checkModel("reset");
        RST = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].tk, vecs[i].se, vecs[i].sd, vecs[i].sv,
                          vecs[i].ld, vecs[i].u, vecs[i].dn);
            checkOutput($sformatf("vec%0d", i), out24, {vecs[i].t, 1'b0, vecs[i].day, vecs[i].err});
            checkModel($sformatf("vec%0d", i));
        end

        $display("[TB] 12 h noon/midnight sequences");
        applyStimulus(0, 1, 0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 1, 0, 0);
        applyStimulus(0, 1, 2, 5, 1, 0, 0);
        applyStimulus(0, 1, 3, 9, 1, 0, 0);
        applyStimulus(0, 1, 4, 5, 1, 0, 0);
        applyStimulus(0, 1, 5, 9, 1, 0, 0);
        applyStimulus(0, 1, 6, 1, 1, 0, 0);
        checkOutput("pm_load/12h", out12, {24'h115959, 3'b100});
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("midnight/12h", out12, {24'h120000, 3'b010});
        checkOutput("noon/24h", out24, {24'h120000, 3'b000});
        checkModel("midnight");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pulse_end/12h", out12, {24'h120000, 3'b000});
        applyStimulus(0, 1, 1, 2, 1, 0, 0);
        applyStimulus(0, 1, 2, 5, 1, 0, 0);
        applyStimulus(0, 1, 3, 9, 1, 0, 0);
        applyStimulus(0, 1, 4, 5, 1, 0, 0);
        applyStimulus(0, 1, 5, 9, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("one_oclock/12h", out12, {24'h010000, 3'b000});
        checkOutput("one_pm/24h", out24, {24'h130000, 3'b000});
        applyStimulus(0, 1, 1, 9, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 1, 0);
        checkOutput("h1_wrap/12h", out12, {24'h010000, 3'b000});
        checkOutput("h1_wrap/24h", out24, {24'h100000, 3'b000});

        $display("[TB] ticks dropped in set mode");
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("set_hold/12h", out12, {24'h010000, 3'b000});
        checkOutput("set_hold/24h", out24, {24'h100000, 3'b000});
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("resume/12h", out12, {24'h010001, 3'b000});
        checkOutput("resume/24h", out24, {24'h100001, 3'b000});
        checkModel("resume");

        $display("[TB] day-of-week rollover");
        applyStimulus(0, 1, 7, 6, 1, 0, 0);
        applyStimulus(0, 1, 0, 2, 1, 0, 0);
        applyStimulus(0, 1, 1, 3, 1, 0, 0);
        applyStimulus(0, 1, 2, 5, 1, 0, 0);
        applyStimulus(0, 1, 3, 9, 1, 0, 0);
        applyStimulus(0, 1, 4, 5, 1, 0, 0);
        applyStimulus(0, 1, 5, 9, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("dow_midnight/24h", out24, {24'h000000, 3'b010});
        if (HAS_DOW) checkDow("dow_wrap/24h", dow_24, 0);
        checkModel("dow_midnight");

        $display("[TB] randomized run");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                      : int'($urandom_range(0, 9)),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 2) == 0));
            checkModel("random");
        end

        $display("[TB] reset during set mode");
        tick = 1'b1; set_en = 1'b1; set_digit = 3'd5; set_value = 4'd3; set_load = 1'b1;
        #3;
        RST = 1'b1;
        #1;
        checkOutput("async_reset/24h", out24, {24'h000000, 3'b000});
        checkOutput("async_reset/12h", out12, {24'h120000, 3'b100});
        if (HAS_DOW) checkDow("async_reset/dow24", dow_24, 0);
        @(posedge CLKk);
        #1;
        RST = 1'b0;
        m24 = model_reset(1'b0, 1'b0);
        m12 = model_reset(1'b1, 1'b1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("after_reset/24h", out24, {24'h000001, 3'b000});
        checkModel("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
